puf_response_collector: RTL and testbench

//  Control/collection stage downstream of the arbiter flip-flop in the arbiter-PUF datapath.
//  For each response bit it:
//   - drives a challenge onto the delay chains and pulses a race launch;
//   - samples the arbiter output through a 2-flop synchroniser;
//   - repeats the race VOTES times and majority-votes the result.
//  It assembles RESP_W voted bits into a word and offers it on a valid/ready handshake.
//  It also counts bits whose votes disagreed, giving a stability figure.

---
 rtl/puf_response_collector_if.sv | 26 ++
 rtl/puf_response_collector.sv | 137 +++++++++++++
 tb/tb_puf_response_collector.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/puf_response_collector_if.sv
// Response-word handshake between the PUF collector and its consumer.
// The collector drives the word and stability count; the consumer drives ready.
interface puf_response_collector_if #(
  parameter int RESP_W = 16
);
  localparam int CW = $clog2(RESP_W + 1);

  logic [RESP_W-1:0] resp_data;
  logic              resp_valid;
  logic              resp_ready;
  logic [CW-1:0]     unstable_cnt;

  modport master (
    output resp_data,
    output resp_valid,
    output unstable_cnt,
    input  resp_ready
  );

  modport slave (
    input  resp_data,
    input  resp_valid,
    input  unstable_cnt,
    output resp_ready
  );
endinterface

// File: rtl/puf_response_collector.sv
// Arbiter-PUF collection stage: launches races, majority-votes the
// synchronised arbiter output and assembles voted bits into a word.
module puf_response_collector #(
  parameter int                CHAL_W   = 32,
  parameter int                RESP_W   = 16,
  parameter int                VOTES    = 5,
  parameter int                SETTLE   = 4,
  parameter logic [CHAL_W-1:0] LFSR_TAP = 32'h80200003
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CHAL_W-1:0] seed,
  output logic              busy,
  output logic [CHAL_W-1:0] challenge,
  output logic              launch,
  input  logic              arb_in,
  puf_response_collector_if.master resp
);

  localparam int OW = $clog2(VOTES + 1);
  localparam int BW = (RESP_W > 1) ? $clog2(RESP_W) : 1;
  localparam int SW = $clog2(SETTLE);
  localparam int CW = $clog2(RESP_W + 1);

  localparam logic [OW-1:0] VLAST = OW'(VOTES - 1);
  localparam logic [OW-1:0] VHALF = OW'(VOTES / 2);
  localparam logic [OW-1:0] VALL  = OW'(VOTES);
  localparam logic [BW-1:0] BLAST = BW'(RESP_W - 1);
  localparam logic [SW-1:0] SLAST = SW'(SETTLE - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_SETTLE,
    S_SAMPLE,
    S_COMMIT,
    S_DONE
  } state_t;

  state_t        state;
  logic          sync1;
  logic          sync2;
  logic [OW-1:0] ones;
  logic [OW-1:0] vote_idx;
  logic [BW-1:0] bit_idx;
  logic [SW-1:0] scnt;
  logic [CHAL_W-1:0] chal_next;

  // One Galois step of the challenge sequence.
  assign chal_next = (challenge >> 1) ^
                     (challenge[0] ? LFSR_TAP : '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= S_IDLE;
      sync1             <= 1'b0;
      sync2             <= 1'b0;
      ones              <= '0;
      vote_idx          <= '0;
      bit_idx           <= '0;
      scnt              <= '0;
      busy              <= 1'b0;
      launch            <= 1'b0;
      challenge         <= '0;
      resp.resp_data    <= '0;
      resp.resp_valid   <= 1'b0;
      resp.unstable_cnt <= '0;
    end else begin
      sync1 <= arb_in;
      sync2 <= sync1;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            challenge <= (seed == '0) ? CHAL_W'(1) : seed;
            bit_idx           <= '0;
            vote_idx          <= '0;
            ones              <= '0;
            resp.resp_data    <= '0;
            resp.unstable_cnt <= '0;
            busy              <= 1'b1;
            launch            <= 1'b1;
            state             <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          launch <= 1'b0;
          scnt   <= '0;
          state  <= S_SETTLE;
        end
        S_SETTLE: begin
          if (scnt == SLAST) begin
            scnt  <= '0;
            state <= S_SAMPLE;
          end else begin
            scnt <= scnt + SW'(1);
          end
        end
        S_SAMPLE: begin
          ones <= ones + OW'(sync2);
          if (vote_idx != VLAST) begin
            vote_idx <= vote_idx + OW'(1);
            launch   <= 1'b1;
            state    <= S_LAUNCH;
          end else begin
            state <= S_COMMIT;
          end
        end
        S_COMMIT: begin
          resp.resp_data[bit_idx] <= (ones > VHALF);
          if (ones != '0 && ones != VALL)
            resp.unstable_cnt <= resp.unstable_cnt + CW'(1);
          challenge <= chal_next;
          ones      <= '0;
          vote_idx  <= '0;
          if (bit_idx == BLAST) begin
            resp.resp_valid <= 1'b1;
            state           <= S_DONE;
          end else begin
            bit_idx <= bit_idx + BW'(1);
            launch  <= 1'b1;
            state   <= S_LAUNCH;
          end
        end
        S_DONE: begin
          if (resp.resp_ready) begin
            resp.resp_valid <= 1'b0;
            busy            <= 1'b0;
            state           <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_puf_response_collector.sv
// Bench for puf_response_collector: cycle-level timeline model plus
// directed word collections with hand-computed results.
module tb_puf_response_collector;
  localparam int RW  = 16;
  localparam int BPC = 31;
  localparam int LAT = 497;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        arb_in;
  logic [31:0] seed;
  logic [31:0] challenge;
  logic        busy;
  logic        launch;

  int vec = 0;
  int err = 0;
  int mode = 0;
  int nlaunch = 0;
  logic [31:0] chal_at [0:99];

  puf_response_collector_if #(.RESP_W(RW)) rif();

  puf_response_collector dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .seed      (seed),
    .busy      (busy),
    .challenge (challenge),
    .launch    (launch),
    .arb_in    (arb_in),
    .resp      (rif.master)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    vec++;
    if (act !== exp) begin
      err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp,
               $time);
    end
  endtask

  // Number of votes (out of 5) on which the arbiter reads 1 for bit b.
  function automatic int votes1(input int m, input int b);
    case (m)
      0: return 5;
      1: return 3;
      2: return 2;
      3: return b % 6;
      default: return 0;
    endcase
  endfunction

  function automatic logic [31:0] lstep(input logic [31:0] c);
    return (c >> 1) ^ (c[0] ? 32'h80200003 : 32'h0);
  endfunction

  // Arbiter stand-in: a new race outcome per launch.
  initial begin
    arb_in = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (launch === 1'b1) begin
        if (nlaunch < 100) chal_at[nlaunch] = challenge;
        arb_in = ((nlaunch % 5) < votes1(mode, nlaunch / 5));
        nlaunch++;
      end
    end
  end

  // Timeline model: 0 idle, 1 collecting, 2 word offered.
  int          m_ph = 0;
  int          m_t = 0;
  logic [15:0] m_full = '0;
  logic [15:0] m_hd = '0;
  int          m_hu = 0;
  int          m_tot = 0;
  logic [31:0] m_hch = '0;
  logic [31:0] m_chs [0:16];
  bit          m_ub [0:15];
  logic        p_rst = 1'b1;
  logic        p_start = 1'b0;
  logic        p_rdy = 1'b0;
  logic [31:0] p_seed = '0;
  int          p_mode = 0;

  always @(negedge clk) begin : model
    int b, p, nb, eu, k;
    logic eb, el, ev;
    logic [31:0] ec, c;
    logic [15:0] ed;
    if (p_rst) begin
      m_ph = 0; m_hd = '0; m_hu = 0; m_hch = '0;
    end else if (m_ph == 0) begin
      if (p_start) begin
        m_ph = 1; m_t = 1; m_hd = '0; m_hu = 0;
        c = (p_seed == 0) ? 32'h1 : p_seed;
        for (int i = 0; i <= 16; i++) begin
          m_chs[i] = c;
          c = lstep(c);
        end
        m_tot = 0;
        for (int i = 0; i < RW; i++) begin
          k = votes1(p_mode, i);
          m_full[i] = (k > 2);
          m_ub[i] = (k != 0 && k != 5);
          if (m_ub[i]) m_tot++;
        end
      end
    end else if (m_ph == 1) begin
      m_t++;
      if (m_t == LAT) m_ph = 2;
    end else if (p_rdy) begin
      m_ph = 0; m_hd = m_full; m_hu = m_tot; m_hch = m_chs[16];
    end

    if (m_ph == 1) begin
      b  = (m_t - 1) / BPC;
      p  = (m_t - 1) % BPC;
      nb = b;
      eb = 1'b1;
      el = (p < 30) && (p % 6 == 0);
      ev = 1'b0;
      ec = m_chs[b];
      ed = m_full & ((16'h1 << nb) - 16'h1);
      eu = 0;
      for (int i = 0; i < nb; i++) if (m_ub[i]) eu++;
    end else if (m_ph == 2) begin
      eb = 1'b1; el = 1'b0; ev = 1'b1;
      ec = m_chs[16]; ed = m_full; eu = m_tot;
    end else begin
      eb = 1'b0; el = 1'b0; ev = 1'b0;
      ec = m_hch; ed = m_hd; eu = m_hu;
    end
    chk("m_busy", busy, eb);
    chk("m_launch", launch, el);
    chk("m_valid", rif.resp_valid, ev);
    chk("m_challenge", challenge, ec);
    chk("m_data", rif.resp_data, ed);
    chk("m_unstable", rif.unstable_cnt, eu);

    p_rst = rst; p_start = start; p_seed = seed;
    p_rdy = rif.resp_ready; p_mode = mode;
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic kick(input logic [31:0] sd, input int m);
    mode = m; nlaunch = 0; seed = sd; start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic run_word(input logic [31:0] sd, input int m,
                          input int hold, input logic [15:0] xd,
                          input int xu);
    int n;
    kick(sd, m);
    n = 1;
    while (rif.resp_valid !== 1'b1 && n < 2000) begin
      tick(1);
      n++;
    end
    chk("latency", n, LAT);
    chk("word", rif.resp_data, xd);
    chk("unstable", rif.unstable_cnt, xu);
    chk("launches", nlaunch, 80);
    for (int i = 0; i < hold; i++) begin
      start = (i == 3);
      seed = 32'h1234;
      tick(1);
    end
    start = 1'b0;
    if (hold > 0) begin
      chk("hold_valid", rif.resp_valid, 1);
      chk("hold_word", rif.resp_data, xd);
      chk("hold_busy", busy, 1);
    end
    rif.resp_ready = 1'b1;
    tick(1);
    rif.resp_ready = 1'b0;
    chk("ack_valid", rif.resp_valid, 0);
    chk("ack_busy", busy, 0);
    chk("idle_word", rif.resp_data, xd);
    tick(3);
    chk("idle_launches", nlaunch, 80);
  endtask

  initial begin
    int k;
    rst = 1'b1; start = 1'b0; seed = '0;
    rif.resp_ready = 1'b0;
    tick(3);
    rst = 1'b0;
    tick(1);
    chk("rst_busy", busy, 0);
    chk("rst_challenge", challenge, 0);
    chk("rst_word", rif.resp_data, 0);

    run_word(32'h1, 0, 0, 16'hFFFF, 0);
    run_word(32'h1, 1, 0, 16'hFFFF, 16);
    run_word(32'h1, 2, 0, 16'h0000, 16);
    run_word(32'hDEADBEEF, 0, 10, 16'hFFFF, 0);

    run_word(32'h0, 0, 0, 16'hFFFF, 0);
    chk("first_challenge", chal_at[0], 32'h1);
    chk("second_challenge", chal_at[5], 32'h80200003);

    kick(32'h5, 0);
    tick(100);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    k = nlaunch;
    tick(50);
    chk("t1_no_launch", nlaunch, k);
    chk("t1_busy", busy, 0);
    chk("t1_word", rif.resp_data, 0);
    chk("t1_challenge", challenge, 0);

    kick(32'hA5A5A5A5, 3);
    k = 0;
    while (nlaunch < 36 && k < 2000) begin
      tick(1);
      k++;
    end
    chk("t6_reach_bit7", nlaunch, 36);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(1);
    chk("t6_cleared", rif.unstable_cnt, 0);
    run_word(32'hA5A5A5A5, 3, 0, 16'h8E38, 11);

    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
